// File: rtl/seq_alu_if.sv
// ---------------------------------------------------------------------------
// seq_alu_if
//   Handshake bundle between an operand-issuing controller and seq_alu.
//
//   Issue side  : in_valid / in_ready with operands a, b and op_code.
//   Result side : out_valid / out_ready with alu_out, c_out and zero.
//
//   Modports
//     master : controller / consumer view (drives operands and out_ready)
//     slave  : ALU view (drives in_ready and the result fields)
// ---------------------------------------------------------------------------
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic [2:0]             op_code;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     alu_out;
    logic                   c_out;
    logic                   zero;

    modport master (
        output in_valid,
        output a,
        output b,
        output op_code,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  alu_out,
        input  c_out,
        input  zero
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  op_code,
        input  out_ready,
        output in_ready,
        output out_valid,
        output alu_out,
        output c_out,
        output zero
    );
endinterface

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu
//   Multi-cycle unsigned ALU with valid/ready handshakes on both sides.
//   One operation in flight at a time. Single-cycle ops (add, sub, and, or,
//   xor, shl) finish on the accept edge; mul (shift-add) and div (restoring)
//   produce one partial product / quotient bit per edge, WIDTH steps total.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : synchronous active-low reset
//     bus    : seq_alu_if.slave
//                in_valid/in_ready, a, b, op_code  (issue side)
//                out_valid/out_ready, alu_out, c_out, zero  (result side)
//
//   alu_out, c_out and zero come straight from registers and read 0 outside
//   the DONE state.
// ---------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_alu_if.slave    bus
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = SH_W;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;

    logic [CNT_W-1:0]       cnt_reg;

    // Multiplier datapath
    logic [2*WIDTH-1:0]     acc_reg;
    logic [2*WIDTH-1:0]     mcand_reg;
    logic [WIDTH-1:0]       mplier_reg;

    // Divider datapath: quo_reg starts as the dividend and is shifted out
    // MSB-first while quotient bits are shifted in at the bottom.
    logic [WIDTH-1:0]       rem_reg;
    logic [WIDTH-1:0]       quo_reg;
    logic [WIDTH-1:0]       divisor_reg;

    // Registered outputs
    logic [2*WIDTH-1:0]     alu_out_reg;
    logic                   c_out_reg;
    logic                   zero_reg;

    logic                   accept;
    logic                   step_last;

    assign accept    = bus.in_valid && (state_reg == IDLE);
    assign step_last = (cnt_reg == CNT_LAST);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    case (bus.op_code)
                        OP_MUL:  state_next = MUL;
                        OP_DIV:  state_next = DIV;
                        default: state_next = DONE;
                    endcase
                end
            end
            MUL, DIV: begin
                if (step_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        bus.in_ready  = (state_reg == IDLE);
        bus.out_valid = (state_reg == DONE);
    end

    assign bus.alu_out = alu_out_reg;
    assign bus.c_out   = c_out_reg;
    assign bus.zero    = zero_reg;

    // -----------------------------------------------------------------------
    // Single-cycle operations, evaluated on the live inputs so the result can
    // be registered on the accept edge itself.
    // -----------------------------------------------------------------------
    logic [WIDTH:0]         add_full;
    logic [WIDTH:0]         sub_full;
    logic [WIDTH-1:0]       and_bits;
    logic [WIDTH-1:0]       or_bits;
    logic [WIDTH-1:0]       xor_bits;
    logic [2*WIDTH-1:0]     shl_full;

    assign add_full = {1'b0, bus.a} + {1'b0, bus.b};
    // The extra MSB of the difference is the borrow (a < b).
    assign sub_full = {1'b0, bus.a} - {1'b0, bus.b};
    assign shl_full = {{WIDTH{1'b0}}, bus.a} << bus.b[SH_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_logic_bit
            assign and_bits[gi] = bus.a[gi] & bus.b[gi];
            assign or_bits[gi]  = bus.a[gi] | bus.b[gi];
            assign xor_bits[gi] = bus.a[gi] ^ bus.b[gi];
        end
    endgenerate

    logic [2*WIDTH-1:0]     single_res;
    logic                   single_c;
    logic                   single_op;

    always_comb begin
        single_res = '0;
        single_c   = 1'b0;
        single_op  = 1'b1;
        case (bus.op_code)
            OP_ADD: begin
                single_res = {{WIDTH{1'b0}}, add_full[WIDTH-1:0]};
                single_c   = add_full[WIDTH];
            end
            OP_SUB: begin
                single_res = {{WIDTH{1'b0}}, sub_full[WIDTH-1:0]};
                single_c   = sub_full[WIDTH];
            end
            OP_AND:  single_res = {{WIDTH{1'b0}}, and_bits};
            OP_OR:   single_res = {{WIDTH{1'b0}}, or_bits};
            OP_XOR:  single_res = {{WIDTH{1'b0}}, xor_bits};
            OP_SHL:  single_res = shl_full;
            default: single_op  = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Iterative step logic. Step 0 is performed on the accept edge straight
    // from the bus operands, so the remaining WIDTH-1 steps finish in time for
    // out_valid to rise WIDTH cycles after accept. The source muxes select the
    // bus on that first step and the working registers afterwards.
    // -----------------------------------------------------------------------
    logic                   first_step;
    assign first_step = (state_reg == IDLE);

    logic [2*WIDTH-1:0]     acc_src;
    logic [2*WIDTH-1:0]     mcand_src;
    logic [WIDTH-1:0]       mplier_src;
    logic [2*WIDTH-1:0]     mul_sum;

    assign acc_src    = first_step ? '0                          : acc_reg;
    assign mcand_src  = first_step ? {{WIDTH{1'b0}}, bus.a}      : mcand_reg;
    assign mplier_src = first_step ? bus.b                       : mplier_reg;
    // Partial products never exceed 2*WIDTH bits, so no carry is lost here.
    assign mul_sum    = acc_src + (mplier_src[0] ? mcand_src : '0);

    logic [WIDTH-1:0]       rem_src;
    logic [WIDTH-1:0]       quo_src;
    logic [WIDTH-1:0]       divisor_src;
    logic [WIDTH:0]         rem_shift;
    logic                   div_ge;
    logic [WIDTH-1:0]       rem_step;
    logic [WIDTH-1:0]       quo_step;

    assign rem_src     = first_step ? '0    : rem_reg;
    assign quo_src     = first_step ? bus.a : quo_reg;
    assign divisor_src = first_step ? bus.b : divisor_reg;

    assign rem_shift = {rem_src, quo_src[WIDTH-1]};
    assign div_ge    = (rem_shift >= {1'b0, divisor_src});
    // When div_ge holds the true difference is below the divisor, so the
    // WIDTH-bit subtraction is exact. A zero divisor always subtracts, which
    // yields an all-ones quotient and leaves the dividend as the remainder.
    assign rem_step  = div_ge ? (rem_shift[WIDTH-1:0] - divisor_src)
                              : rem_shift[WIDTH-1:0];
    assign quo_step  = {quo_src[WIDTH-2:0], div_ge};

    // -----------------------------------------------------------------------
    // Result load selection for the output registers.
    // -----------------------------------------------------------------------
    logic                   load_res;
    logic [2*WIDTH-1:0]     res_val;
    logic                   res_c;
    logic                   clear_res;

    always_comb begin
        load_res = 1'b0;
        res_val  = '0;
        res_c    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept && single_op) begin
                    load_res = 1'b1;
                    res_val  = single_res;
                    res_c    = single_c;
                end
            end
            MUL: begin
                if (step_last) begin
                    load_res = 1'b1;
                    res_val  = mul_sum;
                    res_c    = |mul_sum[2*WIDTH-1:WIDTH];
                end
            end
            DIV: begin
                if (step_last) begin
                    load_res = 1'b1;
                    res_val  = {rem_step, quo_step};
                    res_c    = (divisor_reg == '0);
                end
            end
            default: ;
        endcase
    end

    assign clear_res = (state_reg == DONE) && bus.out_ready;

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            alu_out_reg <= '0;
            c_out_reg   <= 1'b0;
            zero_reg    <= 1'b0;
        end else begin
            // Counter: step 0 happens at accept, so the first stored count is 1.
            // It wraps back to 0 on the final step.
            if (accept) begin
                cnt_reg <= CNT_ONE;
            end else if (state_reg == MUL || state_reg == DIV) begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end

            // Both iterative datapaths are primed on every accept; only the
            // one matching the entered state keeps stepping.
            if (accept || state_reg == MUL) begin
                acc_reg    <= mul_sum;
                mcand_reg  <= {mcand_src[2*WIDTH-2:0], 1'b0};
                mplier_reg <= {1'b0, mplier_src[WIDTH-1:1]};
            end

            if (accept || state_reg == DIV) begin
                rem_reg     <= rem_step;
                quo_reg     <= quo_step;
                divisor_reg <= divisor_src;
            end

            if (load_res) begin
                alu_out_reg <= res_val;
                c_out_reg   <= res_c;
                zero_reg    <= (res_val == '0);
            end else if (clear_res) begin
                alu_out_reg <= '0;
                c_out_reg   <= 1'b0;
                zero_reg    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu
//   Directed bench for seq_alu (WIDTH=8). Expected values are hand-computed
//   constants; every comparison is an immediate assertion.
// ---------------------------------------------------------------------------
module tb_seq_alu;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(8)) bus();

    seq_alu #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation and hold it for exactly the accept edge, then
    // scramble the operands to show later input changes are ignored.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("issue_in_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.op_code  = op;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = ~b;
        bus.op_code  = ~op;
    endtask

    // Latency in cycles: 1 means out_valid is high right after the accept edge.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            check("busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input logic [15:0] exp_res,
                          input logic exp_c, input int exp_lat);
        int lat;
        issue(a, b, op);
        wait_done(lat);
        check({name, "_lat"},   lat, exp_lat);
        check({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({name, "_res"},   {16'd0, bus.alu_out}, {16'd0, exp_res});
        check({name, "_c"},     {31'd0, bus.c_out}, {31'd0, exp_c});
        check({name, "_zero"},  {31'd0, bus.zero}, (exp_res == 16'd0) ? 32'd1 : 32'd0);
        $display("%s: a=%h b=%h op=%b -> alu_out=%h c_out=%b zero=%b lat=%0d",
                 name, a, b, op, bus.alu_out, bus.c_out, bus.zero, lat);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({name, "_post_in_ready"},  {31'd0, bus.in_ready}, 32'd1);
        check({name, "_post_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({name, "_post_res"},       {16'd0, bus.alu_out}, 32'd0);
    endtask

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op_code   = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_alu_out",   {16'd0, bus.alu_out},   32'd0);
        check("rst_c_out",     {31'd0, bus.c_out},     32'd0);
        check("rst_zero",      {31'd0, bus.zero},      32'd0);
        $display("reset: in_ready=%b out_valid=%b alu_out=%h", bus.in_ready, bus.out_valid, bus.alu_out);

        // Add / sub / shift
        run_op("add_ff_55",  8'hFF, 8'h55, 3'b000, 16'h0054, 1'b1, 1);
        run_op("sub_ff_55",  8'hFF, 8'h55, 3'b001, 16'h00AA, 1'b0, 1);
        run_op("sub_55_ff",  8'h55, 8'hFF, 3'b001, 16'h0056, 1'b1, 1);
        run_op("shl_ff_3",   8'hFF, 8'h03, 3'b110, 16'h07F8, 1'b0, 1);
        run_op("shl_ff_0b",  8'hFF, 8'h0B, 3'b110, 16'h07F8, 1'b0, 1);
        run_op("shl_81_7",   8'h81, 8'h07, 3'b110, 16'h4080, 1'b0, 1);

        // Logic ops
        run_op("and_ff_55",  8'hFF, 8'h55, 3'b011, 16'h0055, 1'b0, 1);
        run_op("or_ff_55",   8'hFF, 8'h55, 3'b100, 16'h00FF, 1'b0, 1);
        run_op("xor_ff_55",  8'hFF, 8'h55, 3'b101, 16'h00AA, 1'b0, 1);
        run_op("and_00_00",  8'h00, 8'h00, 3'b011, 16'h0000, 1'b0, 1);
        run_op("add_80_80",  8'h80, 8'h80, 3'b000, 16'h0000, 1'b1, 1);

        // Multiply
        run_op("mul_ff_55",  8'hFF, 8'h55, 3'b010, 16'h54AB, 1'b1, 8);
        run_op("mul_0f_11",  8'h0F, 8'h11, 3'b010, 16'h00FF, 1'b0, 8);
        run_op("mul_ff_ff",  8'hFF, 8'hFF, 3'b010, 16'hFE01, 1'b1, 8);

        // Divide
        run_op("div_ff_55",  8'hFF, 8'h55, 3'b111, 16'h0003, 1'b0, 8);
        run_op("div_ff_00",  8'hFF, 8'h00, 3'b111, 16'hFFFF, 1'b1, 8);
        run_op("div_64_07",  8'h64, 8'h07, 3'b111, 16'h020E, 1'b0, 8);
        run_op("div_03_09",  8'h03, 8'h09, 3'b111, 16'h0300, 1'b0, 8);

        // Backpressure: hold out_ready low for 5 cycles, pulse in_valid meanwhile
        issue(8'hFF, 8'h55, 3'b000);
        wait_done(lat);
        check("bp_lat", lat, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_res",       {16'd0, bus.alu_out}, 32'h0054);
            check("bp_c",         {31'd0, bus.c_out}, 32'd1);
            check("bp_in_ready",  {31'd0, bus.in_ready}, 32'd0);
            if (i == 1) begin
                bus.a        = 8'h01;
                bus.b        = 8'h01;
                bus.op_code  = 3'b000;
                bus.in_valid = 1'b1;
            end
            if (i == 2) begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
        check("bp_res_after_hold", {16'd0, bus.alu_out}, 32'h0054);
        $display("backpressure: alu_out=%h c_out=%b held 5 cycles", bus.alu_out, bus.c_out);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_release_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        check("bp_release_out_valid", {31'd0, bus.out_valid}, 32'd0);
        tick();
        check("bp_pulse_ignored", {31'd0, bus.out_valid}, 32'd0);

        // Reset in the middle of a multiply
        issue(8'hFF, 8'h55, 3'b010);
        tick();
        tick();
        check("mid_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        check("mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mrst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        check("mrst_alu_out",   {16'd0, bus.alu_out}, 32'd0);
        check("mrst_c_out",     {31'd0, bus.c_out}, 32'd0);
        $display("reset mid-mul: in_ready=%b out_valid=%b alu_out=%h", bus.in_ready, bus.out_valid, bus.alu_out);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mrst_no_result", {31'd0, bus.out_valid}, 32'd0);
        end
        run_op("add_after_rst", 8'h12, 8'h34, 3'b000, 16'h0046, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
